hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter LU_CYCLES, default 1, range 1-4: bubble cycles inserted per load-use hazard.
REQ-002 Parameter TIMEOUT, default 255: mem_busy cycles before mem_timeout sets.
REQ-003 One clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 IDEX_MemRead  in  1  instruction in EX is a load.
REQ-007 IDEX_RtorRd_in  in  5  destination register of the EX instruction.
REQ-008 IFID_rs_in  in  5  rs of the ID instruction.
REQ-009 IFID_rt_in  in  5  rt of the ID instruction.
REQ-010 IFID_RtUsed  in  1  ID instruction reads rt as an ALU operand.
REQ-011 IFID_MemWr  in  1  ID instruction is a store; rt is store data.
REQ-012 EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-013 ID_Jump  in  1  jump decoded in ID.
REQ-014 mem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-015 PC_Wr  out  1  PC write enable.
REQ-016 IFID_Wr  out  1  IF/ID write enable.
REQ-017 IFID_flush  out  1  zero IF/ID on the next edge.
REQ-018 IDEX_flush  out  1  insert a bubble into ID/EX on the next edge.
REQ-019 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-020 mem_timeout  out  1  sticky; memory wait exceeded TIMEOUT.
REQ-021 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-022 lu_hit SHALL equal IDEX_MemRead & (IDEX_RtorRd_in!=0) & ((IDEX_RtorRd_in==IFID_rs_in) | (IFID_RtUsed & IDEX_RtorRd_in==IFID_rt_in)).
REQ-023 A hit on rt only, with IFID_MemWr=1 and IFID_RtUsed=0, SHALL NOT stall, because MEM-stage forwarding resolves it.
REQ-024 FSM states SHALL be RUN, LU_STALL and FREEZE.
REQ-025 Outputs SHALL be a combinational (Mealy) function of state and inputs, with zero-cycle latency.
REQ-026 Priority each cycle SHALL be: mem_busy > EX_BranchTaken > load-use > ID_Jump.
REQ-027 When mem_busy=1: pipe_freeze=1, PC_Wr=0, IFID_Wr=0, both flushes=0, next state FREEZE, and the LU down-counter is held.
REQ-028 In FREEZE with mem_busy=0, the FSM SHALL return to the state held before the freeze; the ID stage is re-evaluated on the next cycle.
REQ-029 RUN with EX_BranchTaken=1: IFID_flush=1, IDEX_flush=1, PC_Wr=1, and any lu_hit is ignored.
REQ-030 RUN with lu_hit and no branch: PC_Wr=0, IFID_Wr=0, IDEX_flush=1, counter loaded to LU_CYCLES-1, next state LU_STALL if LU_CYCLES>1, else RUN.
REQ-031 LU_STALL: PC_Wr=0, IFID_Wr=0, IDEX_flush=1, counter decrements, exit to RUN when the counter reads 0.
REQ-032 An EX_BranchTaken in LU_STALL SHALL abort the stall: branch flush outputs apply and the next state is RUN.
REQ-033 ID_Jump alone in RUN: IFID_flush=1, PC_Wr=1, IDEX_flush=0.
REQ-034 Idle default: PC_Wr=1, IFID_Wr=1, all other control outputs 0.
REQ-035 stall_cnt SHALL increment on every cycle with PC_Wr=0 and saturate at 16'hFFFF.
REQ-036 A busy counter SHALL count consecutive mem_busy cycles and clear when mem_busy=0.
REQ-037 mem_timeout SHALL set on the cycle the busy count reaches TIMEOUT and stay set until reset.

Reset
REQ-038 While reset=0: state RUN; LU counter, busy counter, stall_cnt and mem_timeout all 0.
REQ-039 While reset=0, outputs SHALL take the idle default (PC_Wr=1, IFID_Wr=1, others 0).
REQ-040 Reset asserted mid-stall or mid-freeze SHALL abandon the operation immediately, with no residual bubble after release.

Structure
REQ-041 A shared pipeline package SHALL hold the FSM state encoding and the stall_cnt width constant.
REQ-042 The saturating counter SHALL be a separate sub-module, sat_counter, used for both stall_cnt and the busy count.

Verification
REQ-043 lw $8 in EX, add rs=$8 in ID, LU_CYCLES=1 -> one cycle with PC_Wr=0, IFID_Wr=0, IDEX_flush=1; stall_cnt=1.
REQ-044 lw $8 in EX, sw rt=$8 in ID (IFID_RtUsed=0) -> no stall; PC_Wr=1.
REQ-045 lu_hit together with EX_BranchTaken -> IFID_flush=1, IDEX_flush=1, PC_Wr=1; stall_cnt unchanged.
REQ-046 LU_CYCLES=3, hit, then mem_busy for 2 cycles during LU_STALL -> freeze 2 cycles, then 2 remaining stall cycles; total PC_Wr=0 for 5 cycles.
REQ-047 mem_busy held 256 cycles, TIMEOUT=255 -> mem_timeout rises after the 255th busy cycle and stays 1 after mem_busy drops.
REQ-048 reset=0 pulsed during LU_STALL -> outputs return to the idle default immediately; no stall after release.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding and counter widths.
package hazard_stall_unit_pkg;
  localparam int STALL_CNT_W = 16;
  localparam int BUSY_CNT_W  = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use bubbles, branch/jump flushes and
// whole-pipe freeze while data memory is busy, with stall and timeout monitoring.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IDEX_MemRead,
  input  logic [4:0]             IDEX_RtorRd_in,
  input  logic [4:0]             IFID_rs_in,
  input  logic [4:0]             IFID_rt_in,
  input  logic                   IFID_RtUsed,
  input  logic                   IFID_MemWr,
  input  logic                   EX_BranchTaken,
  input  logic                   ID_Jump,
  input  logic                   mem_busy,
  output logic                   PC_Wr,
  output logic                   IFID_Wr,
  output logic                   IFID_flush,
  output logic                   IDEX_flush,
  output logic                   pipe_freeze,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  state_t state, next_state, ret_state, next_ret, eff_state;
  logic [1:0] lu_cnt, lu_cnt_nxt;
  logic rs_hit, rt_hit, lu_hit;
  logic [BUSY_CNT_W-1:0] busy_cnt;

  assign rs_hit = (IDEX_RtorRd_in == IFID_rs_in);
  // A store that only needs rt as data gets it from MEM-stage forwarding.
  assign rt_hit = (IDEX_RtorRd_in == IFID_rt_in) & IFID_RtUsed & ~(IFID_MemWr & ~IFID_RtUsed);
  assign lu_hit = IDEX_MemRead & (IDEX_RtorRd_in != 5'd0) & (rs_hit | rt_hit);

  always_comb begin
    PC_Wr       = 1'b1;
    IFID_Wr     = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    pipe_freeze = 1'b0;
    next_state  = state;
    next_ret    = ret_state;
    lu_cnt_nxt  = lu_cnt;
    // Leaving FREEZE behaves as the interrupted state in the same cycle.
    eff_state   = (state == FREEZE) ? ret_state : state;
    if (!reset) begin
      next_state = RUN;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      PC_Wr       = 1'b0;
      IFID_Wr     = 1'b0;
      next_state  = FREEZE;
      next_ret    = eff_state;
    end else if (EX_BranchTaken) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
      lu_cnt_nxt = 2'd0;
      next_state = RUN;
    end else if (eff_state == LU_STALL) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_flush = 1'b1;
      lu_cnt_nxt = (lu_cnt == 2'd0) ? 2'd0 : lu_cnt - 2'd1;
      next_state = (lu_cnt <= 2'd1) ? RUN : LU_STALL;
    end else if (lu_hit) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_flush = 1'b1;
      lu_cnt_nxt = 2'(LU_CYCLES - 1);
      next_state = (LU_CYCLES > 1) ? LU_STALL : RUN;
    end else begin
      IFID_flush = ID_Jump;
      next_state = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      ret_state <= RUN;
      lu_cnt    <= 2'd0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      lu_cnt    <= lu_cnt_nxt;
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (~PC_Wr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(BUSY_CNT_W)) u_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (~mem_busy),
    .inc   (mem_busy),
    .cnt   (busy_cnt)
  );

  // Sets on the edge that completes the TIMEOUT-th consecutive busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mem_timeout <= 1'b0;
    else if (mem_busy && (32'(busy_cnt) >= TIMEOUT - 1))
      mem_timeout <= 1'b1;
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: two DUTs (LU_CYCLES=1 and 3) share random + directed stimulus;
// a bubble-count reference model predicts every cycle's controls and counters.
module tb_hazard_stall_unit;
  typedef struct packed {
    logic        pc_wr;
    logic        ifid_wr;
    logic        ifid_flush;
    logic        idex_flush;
    logic        freeze;
    logic        timeout;
    logic [15:0] scnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic IDEX_MemRead, IFID_RtUsed, IFID_MemWr, EX_BranchTaken, ID_Jump, mem_busy;
  logic [4:0] IDEX_RtorRd_in, IFID_rs_in, IFID_rt_in;
  logic [1:0] pc_wr, ifid_wr, ifid_flush, idex_flush, freeze, timeout;
  logic [1:0][15:0] scnt;

  obs_t [1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  int lu_p[2] = '{1, 3};
  int rem[2];
  int stalls[2];
  int brun;
  bit tmo;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LU_CYCLES(1), .TIMEOUT(255)) u_lu1 (
    .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_RtorRd_in(IDEX_RtorRd_in),
    .IFID_rs_in(IFID_rs_in), .IFID_rt_in(IFID_rt_in), .IFID_RtUsed(IFID_RtUsed),
    .IFID_MemWr(IFID_MemWr), .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .mem_busy(mem_busy), .PC_Wr(pc_wr[0]), .IFID_Wr(ifid_wr[0]), .IFID_flush(ifid_flush[0]),
    .IDEX_flush(idex_flush[0]), .pipe_freeze(freeze[0]), .mem_timeout(timeout[0]),
    .stall_cnt(scnt[0]));

  hazard_stall_unit #(.LU_CYCLES(3), .TIMEOUT(255)) u_lu3 (
    .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_RtorRd_in(IDEX_RtorRd_in),
    .IFID_rs_in(IFID_rs_in), .IFID_rt_in(IFID_rt_in), .IFID_RtUsed(IFID_RtUsed),
    .IFID_MemWr(IFID_MemWr), .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .mem_busy(mem_busy), .PC_Wr(pc_wr[1]), .IFID_Wr(ifid_wr[1]), .IFID_flush(ifid_flush[1]),
    .IDEX_flush(idex_flush[1]), .pipe_freeze(freeze[1]), .mem_timeout(timeout[1]),
    .stall_cnt(scnt[1]));

  // Drive one cycle of inputs, predict the response, then advance past the next edge.
  task automatic apply(input bit rst_n, input bit mrd, input int rd, input int rs, input int rt,
                       input bit rtu, input bit mwr, input bit br, input bit jmp, input bit busy);
    obs_t [1:0] e;
    bit hit;
    reset = rst_n; IDEX_MemRead = mrd; IDEX_RtorRd_in = 5'(rd); IFID_rs_in = 5'(rs);
    IFID_rt_in = 5'(rt); IFID_RtUsed = rtu; IFID_MemWr = mwr; EX_BranchTaken = br;
    ID_Jump = jmp; mem_busy = busy;
    hit = mrd && rd != 0 && (rd == rs || (rtu && rd == rt));
    if (!rst_n) begin
      brun = 0; tmo = 0;
      for (int i = 0; i < 2; i++) begin
        rem[i] = 0; stalls[i] = 0;
        e[i] = '{pc_wr: 1, ifid_wr: 1, default: 0};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e[i] = '{pc_wr: 1, ifid_wr: 1, default: 0};
        e[i].timeout = tmo;
        e[i].scnt = 16'(stalls[i]);
        if (busy) begin
          e[i].freeze = 1; e[i].pc_wr = 0; e[i].ifid_wr = 0;
        end else if (br) begin
          e[i].ifid_flush = 1; e[i].idex_flush = 1; rem[i] = 0;
        end else if (rem[i] > 0) begin
          e[i].pc_wr = 0; e[i].ifid_wr = 0; e[i].idex_flush = 1; rem[i]--;
        end else if (hit) begin
          e[i].pc_wr = 0; e[i].ifid_wr = 0; e[i].idex_flush = 1; rem[i] = lu_p[i] - 1;
        end else if (jmp) begin
          e[i].ifid_flush = 1;
        end
        if (!e[i].pc_wr && stalls[i] < 65535) stalls[i]++;
      end
      if (busy) begin
        brun++;
        if (brun >= 255) tmo = 1;
      end else brun = 0;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    obs_t [1:0] e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          a = '{pc_wr: pc_wr[i], ifid_wr: ifid_wr[i], ifid_flush: ifid_flush[i],
                idex_flush: idex_flush[i], freeze: freeze[i], timeout: timeout[i], scnt: scnt[i]};
          checks++;
          if (a !== e[i]) begin
            failures++;
            $display("FAIL ctl_lu%0d t=%0t got pc/ifw/iff/idf/frz/tmo=%b stall_cnt=%0d want %b stall_cnt=%0d",
                     lu_p[i], $time, a[21:16], a.scnt, e[i][21:16], e[i].scnt);
          end
        end
      end
    end
  end

  initial begin : driver
    int waited;
    reset = 0; IDEX_MemRead = 0; IDEX_RtorRd_in = 0; IFID_rs_in = 0; IFID_rt_in = 0;
    IFID_RtUsed = 0; IFID_MemWr = 0; EX_BranchTaken = 0; ID_Jump = 0; mem_busy = 0;
    @(posedge clk); #1;
    apply(0, 1, 8, 8, 0, 1, 0, 0, 0, 0);      // reset holds idle despite a hit
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    apply(1, 1, 8, 8, 0, 1, 0, 0, 0, 0);      // lw $8 / add rs=$8
    idle(3);
    apply(1, 1, 8, 1, 8, 0, 1, 0, 0, 0);      // lw $8 / sw rt=$8: no stall
    idle(1);
    apply(1, 1, 8, 8, 0, 1, 0, 1, 0, 0);      // hit + branch: branch wins
    idle(2);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);      // lone jump
    apply(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);      // $0 never hazards
    apply(1, 1, 8, 8, 0, 1, 0, 0, 0, 0);      // LU3: hit, freeze mid-stall
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    apply(1, 1, 5, 2, 5, 1, 0, 0, 0, 0);      // rt hit, then branch aborts LU3 stall
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    apply(1, 1, 8, 8, 0, 1, 0, 0, 0, 0);      // reset pulse mid-stall
    apply(0, 1, 8, 8, 0, 1, 0, 0, 0, 0);
    idle(4);
    for (int k = 0; k < 500; k++) begin
      apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 7) == 0));
    end
    idle(4);
    for (int k = 0; k < 256; k++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);                                   // timeout stays sticky
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk); waited++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
